// File: rtl/reg16_write_arbiter.sv
// reg16_write_arbiter: round-robin write-port arbiter with bounded burst lock for one shared register
module reg16_write_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             lock0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic             lock1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_ld,
    output logic             owner,
    output logic             busy
);
    localparam int CW = $clog2(MAX_LOCK) + 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, state_nx;
    logic            prio;
    logic [CW-1:0]   lock_cnt;
    logic            cnt_top, hold0, hold1, switching;

    assign cnt_top   = lock_cnt == CNT_TOP;
    assign hold0     = req0 & lock0 & ~(req1 & cnt_top);
    assign hold1     = req1 & lock1 & ~(req0 & cnt_top);
    assign switching = state_nx != state;

    // next state: prio breaks ties from IDLE, a lock holds ownership until the contended limit
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req0 & req1) ? (prio ? OWN1 : OWN0) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
            OWN0:    state_nx = hold0 ? OWN0 : req1 ? OWN1 : req0 ? OWN0 : IDLE;
            OWN1:    state_nx = hold1 ? OWN1 : req0 ? OWN0 : req1 ? OWN1 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // tie-break pointer moves away from whoever just gained ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           prio <= 1'b0;
        else if (switching && state_nx != IDLE) prio <= state_nx == OWN0;
    end

    // writes in the current ownership, saturating at the lock limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 lock_cnt <= '0;
        else if (switching)         lock_cnt <= '0;
        else if (reg_ld & ~cnt_top) lock_cnt <= lock_cnt + CW'(1);
    end

    // registered grants, busy flag and sticky owner index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            owner <= 1'b0;
        end else begin
            gnt0  <= state_nx == OWN0;
            gnt1  <= state_nx == OWN1;
            busy  <= state_nx != IDLE;
            owner <= state_nx == OWN1 ? 1'b1 : state_nx == OWN0 ? 1'b0 : owner;
        end
    end

    assign reg_ld = (gnt0 & req0) | (gnt1 & req1);
    assign reg_in = gnt0 ? data0 : gnt1 ? data1 : '0;
endmodule
